cache_nway: RTL and testbench

Parametrised N-way set-associative write-back cache with integrated control FSM, tree pseudo-LRU replacement and a full-cache flush mode. It sits between the CPU-side line interface (one s_line-bit line per access, byte-enabled writes) and physical memory. It replaces the separate datapath/control pair with one block whose way count, set count and line size are parameters.

---
 rtl/cache_nway_pkg.sv | 23 ++
 rtl/cache_nway_plru.sv | 59 +++++
 rtl/cache_nway.sv | 203 ++++++++++++++++++++
 tb/tb_cache_nway.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_nway_pkg.sv
// rtl/cache_nway_pkg.sv - shared types and geometry constants for cache_nway
package cache_nway_pkg;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DEF_S_OFFSET = 5;
  localparam int unsigned DEF_S_INDEX  = 3;
  localparam int unsigned DEF_S_WAY    = 2;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    FILL,
    FLUSH_CHECK,
    FLUSH_WB
  } cache_state_t;

  // Tag takes whatever the offset and index leave of the byte address.
  function automatic int unsigned tag_width(input int unsigned so, input int unsigned si);
    return ADDR_W - so - si;
  endfunction

endpackage

// File: rtl/cache_nway_plru.sv
// rtl/cache_nway_plru.sv - per-set tree pseudo-LRU state and victim selection
module plru_tree
  import cache_nway_pkg::*;
#(
  parameter int unsigned s_index = DEF_S_INDEX,
  parameter int unsigned s_way   = DEF_S_WAY
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [s_index-1:0] set_i,
  input  logic [s_way-1:0]   touch_way_i,
  input  logic               touch_en_i,
  output logic [s_way-1:0]   repl_way_o
);

  localparam int unsigned NUM_WAYS = 1 << s_way;
  localparam int unsigned NUM_SETS = 1 << s_index;

  // Heap-ordered tree: node 1 is the root, children of n are 2n and 2n+1.
  // Bit 0 of each vector is never used. A node bit of 0 steers the victim
  // towards the lower half of its subtree, 1 towards the upper half.
  logic [NUM_WAYS-1:0] bits_q [NUM_SETS];
  logic [NUM_WAYS-1:0] bits_d;

  // Touching a way flips every node on its path to point away from it.
  always_comb begin
    logic [s_way-1:0] node;
    bits_d = bits_q[set_i];
    node   = s_way'(1);
    for (int l = s_way - 1; l >= 0; l--) begin
      bits_d[node] = ~touch_way_i[l];
      node         = (node << 1) | s_way'(touch_way_i[l]);
    end
    bits_d[0] = 1'b0;
  end

  // Follow the node bits from the root to find the replacement way.
  always_comb begin
    logic [s_way-1:0]    node;
    logic [NUM_WAYS-1:0] cur;
    cur        = bits_q[set_i];
    node       = s_way'(1);
    repl_way_o = '0;
    for (int l = s_way - 1; l >= 0; l--) begin
      repl_way_o[l] = cur[node];
      node          = (node << 1) | s_way'(cur[node]);
    end
  end

  // Tree bits: cleared on reset, rewritten for the addressed set on a touch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NUM_SETS; s++) bits_q[s] <= '0;
    end else if (touch_en_i) begin
      bits_q[set_i] <= bits_d;
    end
  end

endmodule

// File: rtl/cache_nway.sv
// rtl/cache_nway.sv - N-way set-associative write-back cache with flush
module cache_nway
  import cache_nway_pkg::*;
#(
  parameter int unsigned s_offset = DEF_S_OFFSET,
  parameter int unsigned s_index  = DEF_S_INDEX,
  parameter int unsigned s_way    = DEF_S_WAY
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_W-1:0]               mem_address,
  input  logic                            mem_read,
  input  logic                            mem_write,
  input  logic [(1 << s_offset)-1:0]      mem_byte_enable256,
  input  logic [(8 << s_offset)-1:0]      mem_wdata256,
  output logic [(8 << s_offset)-1:0]      mem_rdata256,
  output logic                            mem_resp,
  input  logic                            flush_req,
  output logic                            flush_done,
  output logic [ADDR_W-1:0]               pmem_address,
  output logic                            pmem_read,
  output logic                            pmem_write,
  output logic [(8 << s_offset)-1:0]      pmem_wdata,
  input  logic [(8 << s_offset)-1:0]      pmem_rdata,
  input  logic                            pmem_resp
);

  localparam int unsigned S_TAG    = tag_width(s_offset, s_index);
  localparam int unsigned S_LINE   = 8 << s_offset;
  localparam int unsigned S_BYTES  = 1 << s_offset;
  localparam int unsigned NUM_WAYS = 1 << s_way;
  localparam int unsigned NUM_SETS = 1 << s_index;
  localparam int unsigned CNT_W    = s_index + s_way;

  cache_state_t       state_q;
  logic [S_TAG-1:0]   req_tag_q;
  logic [s_index-1:0] set_q;
  logic               op_write_q;
  logic [S_LINE-1:0]  wdata_q;
  logic [S_BYTES-1:0] be_q;
  logic [s_way-1:0]   victim_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [S_LINE-1:0]   data_arr_q [NUM_WAYS][NUM_SETS];
  logic [S_TAG-1:0]    tag_arr_q  [NUM_WAYS][NUM_SETS];
  logic [NUM_SETS-1:0] valid_q    [NUM_WAYS];
  logic [NUM_SETS-1:0] dirty_q    [NUM_WAYS];

  logic               hit, has_inv, victim_dirty, entry_dirty, flushing, cnt_last;
  logic [s_way-1:0]   hit_way, inv_way, plru_way, victim_sel, wb_way;
  logic [s_index-1:0] wb_set;
  logic [S_LINE-1:0]  merged_d;
  logic               compare_hit, write_hit, fill_done, wb_done;
  logic               unused_offset;

  assign unused_offset = ^mem_address[s_offset-1:0];

  // Tag lookup in the latched set; iterating downwards lets the lowest way win.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][set_q] && (tag_arr_q[w][set_q] == req_tag_q)) begin
        hit     = 1'b1;
        hit_way = s_way'(w);
      end
      if (!valid_q[w][set_q]) begin
        has_inv = 1'b1;
        inv_way = s_way'(w);
      end
    end
  end

  assign victim_sel   = has_inv ? inv_way : plru_way;
  assign victim_dirty = valid_q[victim_sel][set_q] && dirty_q[victim_sel][set_q];

  // Writeback source: the flush counter while flushing, otherwise the miss victim.
  assign flushing    = (state_q == FLUSH_CHECK) || (state_q == FLUSH_WB);
  assign wb_way      = flushing ? cnt_q[s_way-1:0] : victim_q;
  assign wb_set      = flushing ? cnt_q[CNT_W-1:s_way] : set_q;
  assign entry_dirty = valid_q[wb_way][wb_set] && dirty_q[wb_way][wb_set];
  assign cnt_last    = &cnt_q;

  // Byte-merge the latched write line onto the hit line.
  always_comb begin
    merged_d = data_arr_q[hit_way][set_q];
    for (int b = 0; b < S_BYTES; b++) begin
      if (be_q[b]) merged_d[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  assign compare_hit = (state_q == COMPARE) && hit;
  assign write_hit   = compare_hit && op_write_q;
  assign fill_done   = (state_q == FILL) && pmem_resp;
  assign wb_done     = ((state_q == WRITEBACK) || (state_q == FLUSH_WB)) && pmem_resp;

  assign mem_resp     = compare_hit;
  assign mem_rdata256 = data_arr_q[hit_way][set_q];
  assign pmem_read    = (state_q == FILL);
  assign pmem_write   = (state_q == WRITEBACK) || (state_q == FLUSH_WB);
  assign pmem_wdata   = data_arr_q[wb_way][wb_set];
  assign pmem_address = pmem_write ? {tag_arr_q[wb_way][wb_set], wb_set, {s_offset{1'b0}}}
                                   : {req_tag_q, set_q, {s_offset{1'b0}}};
  assign flush_done   = ((state_q == FLUSH_CHECK) && !entry_dirty && cnt_last) ||
                        ((state_q == FLUSH_WB) && pmem_resp && cnt_last);

  plru_tree #(
    .s_index(s_index),
    .s_way  (s_way)
  ) u_plru (
    .clk_i      (clk),
    .rst_ni     (rst),
    .set_i      (set_q),
    .touch_way_i(fill_done ? victim_q : hit_way),
    .touch_en_i (compare_hit || fill_done),
    .repl_way_o (plru_way)
  );

  // Control FSM; the CPU request is captured once in IDLE and never re-sampled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_tag_q  <= '0;
      set_q      <= '0;
      op_write_q <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      victim_q   <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_read || mem_write) begin
            req_tag_q  <= mem_address[ADDR_W-1 -: S_TAG];
            set_q      <= mem_address[s_offset +: s_index];
            op_write_q <= mem_write;
            wdata_q    <= mem_wdata256;
            be_q       <= mem_byte_enable256;
            state_q    <= COMPARE;
          end else if (flush_req) begin
            cnt_q   <= '0;
            state_q <= FLUSH_CHECK;
          end
        end
        COMPARE: begin
          if (hit) begin
            state_q <= IDLE;
          end else begin
            victim_q <= victim_sel;
            state_q  <= victim_dirty ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: if (pmem_resp) state_q <= FILL;
        FILL:      if (pmem_resp) state_q <= COMPARE;
        FLUSH_CHECK: begin
          if (entry_dirty) begin
            state_q <= FLUSH_WB;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_last) state_q <= IDLE;
          end
        end
        FLUSH_WB: begin
          if (pmem_resp) begin
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= cnt_last ? IDLE : FLUSH_CHECK;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Valid/dirty bookkeeping for fills, write hits and completed writebacks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else begin
      if (fill_done) begin
        valid_q[victim_q][set_q] <= 1'b1;
        dirty_q[victim_q][set_q] <= 1'b0;
      end
      if (write_hit && (|be_q)) dirty_q[hit_way][set_q] <= 1'b1;
      if (wb_done) dirty_q[wb_way][wb_set] <= 1'b0;
    end
  end

  // Line and tag storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_arr_q[victim_q][set_q] <= pmem_rdata;
      tag_arr_q[victim_q][set_q]  <= req_tag_q;
    end else if (write_hit) begin
      data_arr_q[hit_way][set_q] <= merged_d;
    end
  end

endmodule

// File: tb/tb_cache_nway.sv
// tb/tb_cache_nway.sv - scoreboard bench for cache_nway
module tb_cache_nway;

  localparam int LAT = 2;

  typedef struct {
    bit           chk;
    logic [255:0] data;
  } exp_t;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } pev_t;

  logic         clk;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read, mem_write;
  logic [31:0]  mem_byte_enable256;
  logic [255:0] mem_wdata256, mem_rdata256;
  logic         mem_resp;
  logic         flush_req, flush_done;
  logic [31:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  int   total = 0;
  int   bad   = 0;
  int   flush_done_cnt = 0;
  int   wait_cnt = 0;
  bit   hold_resp = 0;
  exp_t exp_q[$];
  pev_t pmem_log[$];
  logic [255:0] mem_model [logic [31:0]];

  cache_nway dut (
    .clk               (clk),
    .rst               (rst),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_byte_enable256(mem_byte_enable256),
    .mem_wdata256      (mem_wdata256),
    .mem_rdata256      (mem_rdata256),
    .mem_resp          (mem_resp),
    .flush_req         (flush_req),
    .flush_done        (flush_done),
    .pmem_address      (pmem_address),
    .pmem_read         (pmem_read),
    .pmem_write        (pmem_write),
    .pmem_wdata        (pmem_wdata),
    .pmem_rdata        (pmem_rdata),
    .pmem_resp         (pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [255:0] pattern(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = a ^ (32'h9E37_0000 + 32'(i) * 32'h0101_0101);
    return l;
  endfunction

  function automatic logic [255:0] get_line(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return pattern(a);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pmem(input string name, input bit wr, input logic [31:0] addr,
                             input logic [255:0] data);
    pev_t e;
    total++;
    if (pmem_log.size() == 0) begin
      bad++;
      $display("FAIL %s: no memory transfer seen, expected wr=%0d addr=%h", name, wr, addr);
    end else begin
      e = pmem_log.pop_front();
      if (e.wr !== wr || e.addr !== addr || e.data !== data) begin
        bad++;
        $display("FAIL %s: got wr=%0d addr=%h data=%h expected wr=%0d addr=%h data=%h",
                 name, e.wr, e.addr, e.data, wr, addr, data);
      end
    end
  endtask

  task automatic access(input string name, input bit wr, input logic [31:0] addr,
                        input logic [31:0] be, input logic [255:0] wd, input bit chk,
                        input logic [255:0] exp, input int exp_lat);
    int cyc;
    @(negedge clk);
    exp_q.push_back('{chk, exp});
    mem_address        = addr;
    mem_byte_enable256 = be;
    mem_wdata256       = wd;
    mem_write          = wr;
    mem_read           = !wr;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!mem_resp && cyc < 100);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    check({name, " latency"}, 256'(cyc), 256'(exp_lat));
    @(posedge clk);
  endtask

  task automatic do_flush(input string name);
    int start;
    int cyc;
    start = flush_done_cnt;
    @(negedge clk);
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    cyc = 0;
    while (flush_done_cnt == start && cyc < 400) begin
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(posedge clk);
    check({name, " flush_done pulses"}, 256'(flush_done_cnt - start), 256'(1));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Memory responder: answers each held request after LAT idle cycles.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) begin
        total++;
        bad++;
        $display("FAIL pmem_exclusive: read and write both high at %h", pmem_address);
      end
      if (!rst || !(pmem_read || pmem_write) || hold_resp) begin
        wait_cnt = 0;
      end else if (wait_cnt == LAT) begin
        wait_cnt  = 0;
        pmem_resp = 1'b1;
        if (pmem_read) begin
          pmem_rdata = get_line(pmem_address);
          pmem_log.push_back('{1'b0, pmem_address, pmem_rdata});
        end else begin
          mem_model[pmem_address] = pmem_wdata;
          pmem_log.push_back('{1'b1, pmem_address, pmem_wdata});
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  // Response monitor: pops the scoreboard on every mem_resp.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && mem_resp) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got mem_resp with nothing outstanding");
        end else begin
          e = exp_q.pop_front();
          if (e.chk) begin
            total++;
            if (mem_rdata256 !== e.data) begin
              bad++;
              $display("FAIL rdata: got %h expected %h", mem_rdata256, e.data);
            end
          end
        end
      end
      if (flush_done) flush_done_cnt++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] a_line, m40, w4, m4, w1, w7, m7, w0;
    rst = 1'b0;
    mem_address = '0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_byte_enable256 = '0;
    mem_wdata256 = '0;
    flush_req = 1'b0;

    // Phase 1: reset outputs, miss/hit, byte-enabled writes, single-line flush.
    repeat (2) @(negedge clk);
    check("reset mem_resp", mem_resp, 0);
    check("reset flush_done", flush_done, 0);
    check("reset pmem_read", pmem_read, 0);
    check("reset pmem_write", pmem_write, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle pmem_read", pmem_read, 0);

    a_line = pattern(32'h40);
    m40 = {a_line[255:32], 32'hDEAD_BEEF};
    access("rd 0x40 miss", 0, 32'h40, 0, 0, 1, a_line, 5);
    expect_pmem("fill 0x40", 0, 32'h40, a_line);
    access("rd 0x40 hit", 0, 32'h40, 0, 0, 1, a_line, 1);
    check("hit no pmem", 256'(pmem_log.size()), 0);
    access("wr 0x40 be F", 1, 32'h40, 32'h0000_000F, {8{32'hDEAD_BEEF}}, 0, 0, 1);
    access("rd 0x40 merged", 0, 32'h40, 0, 0, 1, m40, 1);
    access("wr 0x60 be 0", 1, 32'h60, 32'h0, {8{32'hFFFF_FFFF}}, 0, 0, 5);
    expect_pmem("fill 0x60", 0, 32'h60, pattern(32'h60));
    access("rd 0x60 unchanged", 0, 32'h60, 0, 0, 1, pattern(32'h60), 1);
    do_flush("flush1");
    expect_pmem("flush1 wb 0x40", 1, 32'h40, m40);
    check("flush1 only dirty", 256'(pmem_log.size()), 0);

    // Phase 2: PLRU victim selection in set 2 with a dirty eviction.
    pulse_reset();
    for (int t = 1; t <= 4; t++) begin
      access("plru fill", 0, 32'(t * 256 + 'h40), 0, 0, 1, pattern(32'(t * 256 + 'h40)), 5);
      expect_pmem("plru fill pmem", 0, 32'(t * 256 + 'h40), pattern(32'(t * 256 + 'h40)));
    end
    w4 = {8{32'h1234_5678}};
    a_line = pattern(32'h440);
    m4 = {w4[255:128], a_line[127:0]};
    access("wr tag4", 1, 32'h440, 32'hFFFF_0000, w4, 0, 0, 1);
    access("touch way2", 0, 32'h340, 0, 0, 1, pattern(32'h340), 1);
    access("touch way0", 0, 32'h140, 0, 0, 1, pattern(32'h140), 1);
    access("touch way1", 0, 32'h240, 0, 0, 1, pattern(32'h240), 1);
    access("rd tag5 evict", 0, 32'h540, 0, 0, 1, pattern(32'h540), 8);
    expect_pmem("evict wb tag4", 1, 32'h440, m4);
    expect_pmem("fill tag5", 0, 32'h540, pattern(32'h540));
    access("tag1 survives", 0, 32'h140, 0, 0, 1, pattern(32'h140), 1);
    access("rd tag4 again", 0, 32'h440, 0, 0, 1, m4, 5);
    expect_pmem("refill tag4", 0, 32'h440, m4);
    check("phase2 no extra pmem", 256'(pmem_log.size()), 0);

    // Phase 3: dirty lines at (set0,way1) and (set7,way3), full flush.
    w1 = {8{32'hCAFE_0001}};
    w7 = {8{32'h5555_AAAA}};
    a_line = pattern(32'h3E0);
    m7 = {a_line[255:64], w7[63:32], a_line[31:0]};
    access("set0 way0", 0, 32'h000, 0, 0, 1, pattern(32'h000), 5);
    access("set0 way1 wr", 1, 32'h100, 32'hFFFF_FFFF, w1, 0, 0, 5);
    access("set7 way0", 0, 32'h0E0, 0, 0, 1, pattern(32'h0E0), 5);
    access("set7 way1", 0, 32'h1E0, 0, 0, 1, pattern(32'h1E0), 5);
    access("set7 way2", 0, 32'h2E0, 0, 0, 1, pattern(32'h2E0), 5);
    access("set7 way3 wr", 1, 32'h3E0, 32'h0000_00F0, w7, 0, 0, 5);
    repeat (6) void'(pmem_log.pop_front());
    do_flush("flush2");
    expect_pmem("flush2 first", 1, 32'h100, w1);
    expect_pmem("flush2 second", 1, 32'h3E0, m7);
    check("flush2 count", 256'(pmem_log.size()), 0);
    access("reread set0", 0, 32'h100, 0, 0, 1, w1, 1);
    access("reread set7", 0, 32'h3E0, 0, 0, 1, m7, 1);

    // Phase 4: reset while a writeback is outstanding.
    w0 = {248'h0, 8'h77};
    access("dirty set7 way0", 1, 32'h0E0, 32'h1, w0, 0, 0, 1);
    access("touch set7 way1", 0, 32'h1E0, 0, 0, 1, pattern(32'h1E0), 1);
    access("touch set7 way3", 0, 32'h3E0, 0, 0, 1, m7, 1);
    @(negedge clk);
    hold_resp   = 1'b1;
    mem_address = 32'h4E0;
    mem_read    = 1'b1;
    repeat (4) @(negedge clk);
    check("stuck wb pmem_write", pmem_write, 1);
    check("stuck wb address", pmem_address, 32'h0E0);
    #2;
    rst = 1'b0;
    #1;
    check("async drop pmem_write", pmem_write, 0);
    check("async drop pmem_read", pmem_read, 0);
    check("reset no mem_resp", mem_resp, 0);
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    hold_resp = 1'b0;
    access("post-reset 0xE0", 0, 32'h0E0, 0, 0, 1, pattern(32'h0E0), 5);
    expect_pmem("post-reset fill 0xE0", 0, 32'h0E0, pattern(32'h0E0));
    access("post-reset 0x100", 0, 32'h100, 0, 0, 1, w1, 5);
    expect_pmem("post-reset fill 0x100", 0, 32'h100, w1);
    check("phase4 no extra pmem", 256'(pmem_log.size()), 0);

    repeat (5) @(posedge clk);
    check("scoreboard drained", 256'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
